core_boot_sequencer: RTL and testbench

//  Parametrised core power/boot sequencer. Copies an OS image of IMAGE_WORDS words from boot ROM into

---
 rtl/core_boot_sequencer.sv | 155 +++++++++++++++
 tb/tb_core_boot_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_boot_sequencer.sv
// rtl/core_boot_sequencer.sv - copies the boot image from ROM to IMEM, then releases the core
// A word is retried after TIMEOUT silent cycles; when the retry budget runs out the block parks in ERROR.
module core_boot_sequencer #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int IMAGE_WORDS = 256,
   parameter int ROM_BASE    = 0,
   parameter int IMEM_BASE   = 0,
   parameter int TIMEOUT     = 64,
   parameter int MAX_RETRY   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              restart,
   output logic              rom_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_valid,
   input  logic [DATA_W-1:0] rom_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              loading_os,
   output logic              core_rst_n,
   output logic              load_error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMAGE_WORDS - 1);
   localparam logic [ADDR_W-1:0] ROM_B    = ADDR_W'(ROM_BASE);
   localparam logic [ADDR_W-1:0] IMEM_B   = ADDR_W'(IMEM_BASE);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_OFF,
      S_LOAD_REQ,
      S_LOAD_WAIT,
      S_ON,
      S_ERROR
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [RTY_W-1:0]  retry;
   logic [TMR_W-1:0]  timer;

   logic load_start;
   logic word_done;
   logic timed_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_OFF;
      end else begin
         state <= state_nxt;
      end
   end

   // restart outranks start, which outranks every normal transition
   always_comb begin
      state_nxt  = state;
      load_start = 1'b0;
      word_done  = 1'b0;
      timed_out  = 1'b0;
      if (restart) begin
         state_nxt  = S_LOAD_REQ;
         load_start = 1'b1;
      end else if (start) begin
         if (state == S_OFF) begin
            state_nxt  = S_LOAD_REQ;
            load_start = 1'b1;
         end else begin
            state_nxt = S_OFF;
         end
      end else begin
         case (state)
            S_LOAD_REQ: state_nxt = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
               if (rom_valid) begin
                  word_done = 1'b1;
                  state_nxt = (idx == LAST_IDX) ? S_ON : S_LOAD_REQ;
               end else if (timer == TMR_LAST) begin
                  timed_out = 1'b1;
                  state_nxt = (retry < RTY_MAX) ? S_LOAD_REQ : S_ERROR;
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      rom_req    = 1'b0;
      rom_addr   = '0;
      loading_os = 1'b0;
      core_rst_n = 1'b0;
      load_error = 1'b0;
      case (state)
         S_LOAD_REQ: begin
            rom_req    = 1'b1;
            rom_addr   = ROM_B + idx;
            loading_os = 1'b1;
         end
         S_LOAD_WAIT: loading_os = 1'b1;
         S_ON:        core_rst_n = 1'b1;
         S_ERROR:     load_error = 1'b1;
         default:     rom_req    = 1'b0;
      endcase
   end

   // the IMEM write lands one cycle after the accepted ROM reply, using the index it answered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         retry        <= '0;
         timer        <= '0;
         words_loaded <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
      end else begin
         imem_we <= word_done;
         if (word_done) begin
            imem_addr  <= IMEM_B + idx;
            imem_wdata <= rom_data;
         end

         if (load_start) begin
            idx          <= '0;
            retry        <= '0;
            words_loaded <= '0;
         end else if (word_done) begin
            retry        <= '0;
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
            if (idx != LAST_IDX) begin
               idx <= idx + ADDR_W'(1);
            end
         end else if (timed_out && (retry < RTY_MAX)) begin
            retry <= retry + RTY_W'(1);
         end

         if (state == S_LOAD_WAIT) begin
            timer <= timer + TMR_W'(1);
         end else begin
            timer <= '0;
         end
      end
   end

endmodule

// File: tb/tb_core_boot_sequencer.sv
// tb/tb_core_boot_sequencer.sv - directed bench for core_boot_sequencer with a 1-cycle-latency ROM model
// The ROM answers each request one cycle later with data = address + 0xA0, unless told to stay silent.
module tb_core_boot_sequencer;

   localparam int AW     = 16;
   localparam int DW     = 32;
   localparam int NW     = 4;
   localparam int ROM_B  = 8;
   localparam int IMEM_B = 'h40;
   localparam int TMO    = 8;
   localparam int RTY    = 3;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          start     = 1'b0;
   logic          restart   = 1'b0;
   logic          rom_valid = 1'b0;
   logic [DW-1:0] rom_data  = '0;
   logic          rom_req;
   logic [AW-1:0] rom_addr;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;
   logic          loading_os;
   logic          core_rst_n;
   logic          load_error;
   logic [AW:0]   words_loaded;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic          pend      = 1'b0;
   logic          stray     = 1'b0;
   logic [DW-1:0] pend_data = '0;
   int            skip_cnt[NW];
   logic [AW-1:0] req_addr[$];
   int            req_cyc[$];
   logic [AW-1:0] we_addr[$];
   logic [DW-1:0] we_data[$];

   always #5 clk = ~clk;

   core_boot_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .IMAGE_WORDS(NW), .ROM_BASE(ROM_B),
      .IMEM_BASE(IMEM_B), .TIMEOUT(TMO), .MAX_RETRY(RTY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .restart(restart),
      .rom_req(rom_req), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .loading_os(loading_os), .core_rst_n(core_rst_n), .load_error(load_error),
      .words_loaded(words_loaded)
   );

   // ROM model and activity log, evaluated 2 time units after each rising edge
   always begin
      int k;
      @(posedge clk);
      cyc++;
      #2;
      if (!rst_n) pend = 1'b0;
      rom_valid = pend | stray;
      rom_data  = pend_data;
      if (imem_we === 1'b1) begin
         we_addr.push_back(imem_addr);
         we_data.push_back(imem_wdata);
      end
      pend = 1'b0;
      if (rom_req === 1'b1) begin
         req_addr.push_back(rom_addr);
         req_cyc.push_back(cyc);
         k = int'(rom_addr) - ROM_B;
         if (k >= 0 && k < NW && skip_cnt[k] > 0) begin
            skip_cnt[k]--;
         end else begin
            pend      = 1'b1;
            pend_data = DW'(rom_addr) + 32'hA0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      req_addr.delete();
      req_cyc.delete();
      we_addr.delete();
      we_data.delete();
   endtask

   task automatic wait_on(input string tag, input int limit);
      int n = 0;
      while (core_rst_n !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk(tag, 64'(core_rst_n), 64'd1);
   endtask

   task automatic wait_req(input string tag, input int addr, input int limit);
      int n = 0;
      while (!(rom_req === 1'b1 && int'(rom_addr) == addr) && n < limit) begin
         tick();
         n++;
      end
      chk(tag, 64'(rom_addr), 64'(addr));
   endtask

   initial begin
      int n;
      int c10[$];
      foreach (skip_cnt[i]) skip_cnt[i] = 0;

      // reset values
      tick();
      tick();
      chk("rst_rom_req", 64'(rom_req), 0);
      chk("rst_rom_addr", 64'(rom_addr), 0);
      chk("rst_imem_we", 64'(imem_we), 0);
      chk("rst_imem_addr", 64'(imem_addr), 0);
      chk("rst_imem_wdata", 64'(imem_wdata), 0);
      chk("rst_core_rst_n", 64'(core_rst_n), 0);
      chk("rst_loading_os", 64'(loading_os), 0);
      chk("rst_load_error", 64'(load_error), 0);
      chk("rst_words", 64'(words_loaded), 0);
      rst_n = 1'b1;
      tick();
      chk("off_idle_req", 64'(rom_req), 0);

      // 1: clean boot of 4 words
      clear_logs();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_req0", 64'(rom_req), 1);
      chk("t1_addr0", 64'(rom_addr), 64'(ROM_B));
      chk("t1_loading", 64'(loading_os), 1);
      n = 1;
      while (core_rst_n !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("t1_on_cycle", 64'(n), 9);
      chk("t1_last_we", 64'(imem_we), 1);
      tick();
      chk("t1_words", 64'(words_loaded), 4);
      chk("t1_req_cnt", 64'(req_addr.size()), 4);
      chk("t1_we_cnt", 64'(we_addr.size()), 4);
      for (int i = 0; i < NW && i < we_addr.size(); i++) begin
         chk("t1_we_addr", 64'(we_addr[i]), 64'(IMEM_B + i));
         chk("t1_we_data", 64'(we_data[i]), 64'(32'hA0 + ROM_B + i));
      end
      chk("t1_loading_off", 64'(loading_os), 0);

      // 2: word 2 never answers -> 4 requests 9 cycles apart, then ERROR
      clear_logs();
      skip_cnt[2] = 100;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("t2_core_rst_fall", 64'(core_rst_n), 0);
      chk("t2_req_addr0", 64'(rom_addr), 64'(ROM_B));
      n = 0;
      while (load_error !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("t2_load_error", 64'(load_error), 1);
      chk("t2_core_rst_n", 64'(core_rst_n), 0);
      chk("t2_loading", 64'(loading_os), 0);
      chk("t2_words", 64'(words_loaded), 2);
      tick();
      chk("t2_we_cnt", 64'(we_addr.size()), 2);
      foreach (req_addr[i]) if (int'(req_addr[i]) == ROM_B + 2) c10.push_back(req_cyc[i]);
      chk("t2_w2_req_cnt", 64'(c10.size()), 4);
      for (int i = 1; i < c10.size(); i++) chk("t2_spacing", 64'(c10[i] - c10[i-1]), 9);
      chk("t2_still_error", 64'(load_error), 1);

      // 3: word 1 answers on 2nd request, word 3 needs all 3 retries -> retry must clear per word
      clear_logs();
      skip_cnt[2] = 0;
      skip_cnt[1] = 1;
      skip_cnt[3] = 3;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("t3_error_cleared", 64'(load_error), 0);
      wait_on("t3_on", 300);
      tick();
      chk("t3_words", 64'(words_loaded), 4);
      chk("t3_req_cnt", 64'(req_addr.size()), 8);
      chk("t3_we_cnt", 64'(we_addr.size()), 4);
      for (int i = 0; i < NW && i < we_addr.size(); i++) chk("t3_we_addr", 64'(we_addr[i]), 64'(IMEM_B + i));

      // 4: restart while waiting on word 2 drops that word
      clear_logs();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      wait_req("t4_reach_w2", ROM_B + 2, 40);
      tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("t4_no_we", 64'(imem_we), 0);
      chk("t4_req", 64'(rom_req), 1);
      chk("t4_addr", 64'(rom_addr), 64'(ROM_B));
      chk("t4_words", 64'(words_loaded), 0);
      tick();
      chk("t4_we_cnt", 64'(we_addr.size()), 2);
      wait_on("t4_on", 60);
      tick();
      chk("t4_words_done", 64'(words_loaded), 4);
      chk("t4_we_total", 64'(we_addr.size()), 6);

      // 5: start+restart in ON -> reload; start alone -> OFF
      start = 1'b1;
      restart = 1'b1;
      tick();
      start = 1'b0;
      restart = 1'b0;
      chk("t5_req", 64'(rom_req), 1);
      chk("t5_addr", 64'(rom_addr), 64'(ROM_B));
      chk("t5_core_rst", 64'(core_rst_n), 0);
      wait_on("t5_on", 60);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_off_core_rst", 64'(core_rst_n), 0);
      chk("t5_off_loading", 64'(loading_os), 0);
      chk("t5_off_req", 64'(rom_req), 0);
      tick();
      chk("t5_off_words", 64'(words_loaded), 4);

      // start during load aborts to OFF, word count held
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (words_loaded != 1 && n < 40) begin
         tick();
         n++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ab_loading", 64'(loading_os), 0);
      chk("ab_req", 64'(rom_req), 0);
      tick();
      tick();
      chk("ab_words", 64'(words_loaded), 1);

      // 6: async reset mid-load, then stray rom_valid while OFF
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_req("t6_reach_w1", ROM_B + 1, 40);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t6_async_loading", 64'(loading_os), 0);
      chk("t6_async_words", 64'(words_loaded), 0);
      chk("t6_async_we", 64'(imem_we), 0);
      chk("t6_async_req", 64'(rom_req), 0);
      tick();
      tick();
      clear_logs();
      rst_n = 1'b1;
      stray = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_stray_we", 64'(imem_we), 0);
         chk("t6_stray_req", 64'(rom_req), 0);
      end
      stray = 1'b0;
      tick();
      chk("t6_we_log", 64'(we_addr.size()), 0);
      chk("t6_req_log", 64'(req_addr.size()), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_restart_addr", 64'(rom_addr), 64'(ROM_B));
      wait_on("t6_on", 60);
      chk("t6_words", 64'(words_loaded), 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
